// File: rtl/uart_tx_pkg.sv
// Shared constants for the UART TX front-end arbiter.
// Frame-scheduler state encodings and default widths/limits.
package uart_tx_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LAUNCH    = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_BUSY_TIMEOUT = 8;

    typedef logic [1:0] arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first valid bit at or after rr_ptr,
// searching upward with wrap-around.
module rr_priority_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] winner_oh,
    output logic [IDX_W-1:0]   winner_idx
);

    int   pos;
    logic found;

    always_comb begin
        winner_oh  = '0;
        winner_idx = '0;
        found      = 1'b0;
        pos        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(rr_ptr) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            if (!found && req_valid[pos[IDX_W-1:0]]) begin
                found                        = 1'b1;
                winner_oh[pos[IDX_W-1:0]]    = 1'b1;
                winner_idx                   = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART TX core between NUM_REQ producers.
// Grants, latches the winner's byte/parity, launches and tracks the frame.
module uart_tx_arbiter
    import uart_tx_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
    localparam int IDX_W       = $clog2(NUM_REQ),
    localparam int CNT_W       = $clog2(BUSY_TIMEOUT + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_par_en,
    input  logic [NUM_REQ-1:0]            req_par_typ,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx_data_valid,
    output logic [DATA_WIDTH-1:0]         tx_p_data,
    output logic                          tx_par_en,
    output logic                          tx_par_typ,
    input  logic                          tx_busy,
    output logic [IDX_W-1:0]              grant_id,
    output logic                          active,
    output logic                          err_timeout
);

    arb_state_t              state_q, state_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0]      req_ready_q, req_ready_d;
    logic                    dv_q, dv_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    par_en_q, par_en_d;
    logic                    par_typ_q, par_typ_d;
    logic [IDX_W-1:0]        grant_id_q, grant_id_d;
    logic                    active_q, active_d;
    logic                    err_q, err_d;

    logic [NUM_REQ-1:0]      win_oh;
    logic [IDX_W-1:0]        win_idx;
    logic [DATA_WIDTH-1:0]   win_data;
    logic                    win_par_en;
    logic                    win_par_typ;
    logic [IDX_W-1:0]        next_ptr;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_valid  (req_valid),
        .rr_ptr     (rr_ptr_q),
        .winner_oh  (win_oh),
        .winner_idx (win_idx)
    );

    always_comb begin
        win_data    = '0;
        win_par_en  = 1'b0;
        win_par_typ = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) begin
                win_data    = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                win_par_en  = req_par_en[i];
                win_par_typ = req_par_typ[i];
            end
        end
    end

    // Both frame completion and timeout hand priority to the next index.
    assign next_ptr = (grant_id_q == IDX_W'(NUM_REQ - 1))
                    ? '0
                    : grant_id_q + IDX_W'(1);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        grant_id_d  = grant_id_q;
        data_d      = data_q;
        par_en_d    = par_en_q;
        par_typ_d   = par_typ_q;
        active_d    = active_q;
        req_ready_d = '0;
        dv_d        = 1'b0;
        err_d       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|win_oh) begin
                    data_d      = win_data;
                    par_en_d    = win_par_en;
                    par_typ_d   = win_par_typ;
                    grant_id_d  = win_idx;
                    req_ready_d = win_oh;
                    dv_d        = 1'b1;
                    active_d    = 1'b1;
                    state_d     = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                cnt_d   = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(BUSY_TIMEOUT)) begin
                        err_d    = 1'b1;
                        active_d = 1'b0;
                        rr_ptr_d = next_ptr;
                        state_d  = ST_IDLE;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    active_d = 1'b0;
                    rr_ptr_d = next_ptr;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            req_ready_q <= '0;
            dv_q        <= 1'b0;
            data_q      <= '0;
            par_en_q    <= 1'b0;
            par_typ_q   <= 1'b0;
            grant_id_q  <= '0;
            active_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            dv_q        <= dv_d;
            data_q      <= data_d;
            par_en_q    <= par_en_d;
            par_typ_q   <= par_typ_d;
            grant_id_q  <= grant_id_d;
            active_q    <= active_d;
            err_q       <= err_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign tx_data_valid = dv_q;
    assign tx_p_data     = data_q;
    assign tx_par_en     = par_en_q;
    assign tx_par_typ    = par_typ_q;
    assign grant_id      = grant_id_q;
    assign active        = active_q;
    assign err_timeout   = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed + randomized bench for uart_tx_arbiter with a simple TX core model
// and a round-robin reference model of the grant order.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [N-1:0]      req_par_en = '0;
    logic [N-1:0]      req_par_typ = '0;
    logic              tx_busy = 1'b0;
    logic [N-1:0]      req_ready;
    logic              tx_data_valid;
    logic [DW-1:0]     tx_p_data;
    logic              tx_par_en;
    logic              tx_par_typ;
    logic [1:0]        grant_id;
    logic              active;
    logic              err_timeout;

    int errors = 0;
    int checks = 0;
    int model_ptr = 0;
    logic [N-1:0] valid_at_edge = '0;
    int core_mode = 0;
    int core_len = 11;
    int core_cnt = 0;

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .DATA_WIDTH   (DW),
        .BUSY_TIMEOUT (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_par_en    (req_par_en),
        .req_par_typ   (req_par_typ),
        .req_ready     (req_ready),
        .tx_data_valid (tx_data_valid),
        .tx_p_data     (tx_p_data),
        .tx_par_en     (tx_par_en),
        .tx_par_typ    (tx_par_typ),
        .tx_busy       (tx_busy),
        .grant_id      (grant_id),
        .active        (active),
        .err_timeout   (err_timeout)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) valid_at_edge = req_valid;

    // Core model: Busy rises one cycle after Data_valid, holds core_len cycles.
    always @(negedge clk) begin
        case (core_mode)
            0: begin
                if (tx_data_valid === 1'b1) begin
                    tx_busy  = 1'b1;
                    core_cnt = core_len;
                end else if (core_cnt > 1) begin
                    core_cnt = core_cnt - 1;
                end else begin
                    core_cnt = 0;
                    tx_busy  = 1'b0;
                end
            end
            1: begin
                core_cnt = 0;
                tx_busy  = 1'b0;
            end
            default: tx_busy = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (p + k) % N;
            if (v[j] === 1'b1) return j;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [7:0] d,
                           input logic pe, input logic pt);
        req_data[i*DW +: DW] = d;
        req_par_en[i]  = pe;
        req_par_typ[i] = pt;
        req_valid[i]   = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req_valid = '0;
        core_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_ptr = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_dv"}, 32'(tx_data_valid), 32'd0);
        chk({tag, "_pdata"}, 32'(tx_p_data), 32'd0);
        chk({tag, "_paren"}, 32'(tx_par_en), 32'd0);
        chk({tag, "_partyp"}, 32'(tx_par_typ), 32'd0);
        chk({tag, "_gid"}, 32'(grant_id), 32'd0);
        chk({tag, "_active"}, 32'(active), 32'd0);
        chk({tag, "_err"}, 32'(err_timeout), 32'd0);
    endtask

    task automatic grant_check(input bit refill, output int gid,
                               output int lat);
        int c;
        bit found;
        int exp;
        logic [7:0] ed;
        logic epe;
        logic ept;
        c = 0;
        found = 1'b0;
        gid = -1;
        while (!found && c < 64) begin
            @(posedge clk);
            #1;
            c++;
            found = (req_ready !== '0);
        end
        lat = c;
        chk("grant_seen", 32'(found), 32'd1);
        if (!found) return;
        gid = int'(grant_id);
        exp = model_pick(valid_at_edge, model_ptr);
        chk("grant_had_valid", 32'(exp >= 0), 32'd1);
        if (exp < 0) return;
        ed  = req_data[exp*DW +: DW];
        epe = req_par_en[exp];
        ept = req_par_typ[exp];
        chk("ready_onehot", 32'(req_ready), 32'd1 << exp);
        chk("grant_id", 32'(grant_id), 32'(exp));
        chk("dv_launch", 32'(tx_data_valid), 32'd1);
        chk("active_launch", 32'(active), 32'd1);
        chk("p_data", 32'(tx_p_data), 32'(ed));
        chk("par_en", 32'(tx_par_en), 32'(epe));
        chk("par_typ", 32'(tx_par_typ), 32'(ept));
        model_ptr = (exp + 1) % N;
        if (refill) begin
            req_data[exp*DW +: DW] = 8'($urandom);
        end else begin
            req_valid[exp] = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("dv_one_cycle", 32'(tx_data_valid), 32'd0);
        chk("ready_one_cycle", 32'(req_ready), 32'd0);
        chk("p_data_hold", 32'(tx_p_data), 32'(ed));
    endtask

    task automatic frame_check(input int exp_d);
        int d;
        d = 1;
        while (active === 1'b1 && d < exp_d + 20) begin
            @(posedge clk);
            #1;
            d++;
        end
        chk("frame_len", 32'(d), 32'(exp_d));
        chk("no_err", 32'(err_timeout), 32'd0);
    endtask

    initial begin
        int g;
        int l;

        #1 rst = 1'b0;
        #2 chk_all_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Single request
        core_len = 11;
        set_req(2, 8'hA5, 1'b1, 1'b1);
        grant_check(1'b0, g, l);
        chk("single_latency", 32'(l), 32'd1);
        chk("single_gid", 32'(g), 32'd2);
        frame_check(12);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("single_idle_ready", 32'(req_ready), 32'd0);
        end

        // Fairness
        do_reset();
        for (int i = 0; i < N; i++) begin
            set_req(i, 8'($urandom), 1'($urandom), 1'($urandom));
        end
        for (int r = 0; r < N; r++) begin
            core_len = $urandom_range(2, 12);
            grant_check(1'b0, g, l);
            chk("fair_order", 32'(g), 32'(r));
            frame_check(core_len + 1);
        end

        // Round-robin rotation
        do_reset();
        set_req(1, 8'h3C, 1'b0, 1'b0);
        set_req(3, 8'hC3, 1'b1, 1'b0);
        for (int r = 0; r < 4; r++) begin
            core_len = $urandom_range(2, 9);
            grant_check(1'b1, g, l);
            chk("rotate_order", 32'(g), (r % 2 == 0) ? 32'd1 : 32'd3);
            frame_check(core_len + 1);
        end
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;

        // Timeout
        do_reset();
        core_mode = 1;
        set_req(1, 8'h5A, 1'b1, 1'b0);
        grant_check(1'b0, g, l);
        chk("to_gid", 32'(g), 32'd1);
        for (int k = 2; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (k == 9) begin
                chk("to_err_pulse", 32'(err_timeout), 32'd1);
                chk("to_active_low", 32'(active), 32'd0);
            end else begin
                chk("to_err_quiet", 32'(err_timeout), 32'd0);
                if (k < 9) chk("to_active_high", 32'(active), 32'd1);
            end
        end
        core_mode = 0;
        core_len = 5;
        set_req(0, 8'h11, 1'b0, 1'b1);
        set_req(2, 8'h22, 1'b1, 1'b1);
        set_req(3, 8'h33, 1'b0, 1'b0);
        grant_check(1'b0, g, l);
        chk("to_next_gid", 32'(g), 32'd2);
        frame_check(6);
        req_valid = '0;

        // Reset mid-frame
        do_reset();
        core_len = 11;
        set_req(3, 8'($urandom) | 8'h01, 1'b1, 1'b1);
        grant_check(1'b0, g, l);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_active_before", 32'(active), 32'd1);
        rst = 1'b0;
        #1 chk_all_zero("mid_reset");
        req_valid = '0;
        set_req(0, 8'h81, 1'b1, 1'b0);
        set_req(2, 8'h42, 1'b0, 1'b1);
        model_ptr = 0;
        @(posedge clk);
        #1;
        chk("mid_held_ready", 32'(req_ready), 32'd0);
        rst = 1'b1;
        grant_check(1'b0, g, l);
        chk("mid_first_gid", 32'(g), 32'd0);
        frame_check(core_len + 1);
        req_valid = '0;

        // Idle stability
        do_reset();
        core_mode = 2;
        repeat (50) begin
            @(posedge clk);
            #1;
            chk("idle_ready", 32'(req_ready), 32'd0);
            chk("idle_dv", 32'(tx_data_valid), 32'd0);
            chk("idle_active", 32'(active), 32'd0);
        end
        core_mode = 0;
        repeat (3) @(posedge clk);
        #1;

        // Randomized traffic against the round-robin model
        do_reset();
        repeat (24) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    set_req(i, 8'($urandom), 1'($urandom), 1'($urandom));
                end
            end
            if (req_valid == '0) begin
                set_req($urandom_range(0, N - 1), 8'($urandom),
                        1'($urandom), 1'($urandom));
            end
            core_len = $urandom_range(2, 12);
            grant_check(1'b0, g, l);
            frame_check(core_len + 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one UART TX core (serializer, parity calculator, frame FSM, output mux) between `NUM_REQ` byte producers. It selects one pending requester, latches that requester's byte and parity configuration, and launches the frame with a single-cycle `Data_valid` pulse. It then tracks the core's `Busy` until the frame completes before it grants again. It sits directly upstream of the UART TX top and drives its `P_DATA`, `Data_valid`, `PAR_EN` and `PAR_TYP` inputs.

## Interface
- `NUM_REQ`, default 4: number of requesters (2..8).
- `DATA_WIDTH`, default 8: frame payload width.
- `BUSY_TIMEOUT`, default 8: maximum cycles to wait for `tx_busy` to rise after launch (≥2).
- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ: per-requester byte pending; held until that requester's `req_ready` is seen.
- `req_data`  in  NUM_REQ*DATA_WIDTH: requester i's byte in slice [i*DATA_WIDTH +: DATA_WIDTH].
- `req_par_en`  in  NUM_REQ: per-requester parity enable.
- `req_par_typ`  in  NUM_REQ: per-requester parity type (0 even, 1 odd).
- `req_ready`  out  NUM_REQ: one-hot, one-cycle acceptance pulse.
- `tx_data_valid`  out  1: one-cycle launch pulse to the core.
- `tx_p_data`  out  DATA_WIDTH: latched byte, stable from launch until the frame ends.
- `tx_par_en`, `tx_par_typ`  out  1 each: latched parity configuration, stable like `tx_p_data`.
- `tx_busy`  in  1: the core's `Busy`.
- `grant_id`  out  clog2(NUM_REQ): index of the current or last granted requester.
- `active`  out  1: high from launch until the frame completes or the launch times out.
- `err_timeout`  out  1: one-cycle pulse when `tx_busy` fails to rise within `BUSY_TIMEOUT`.

## Operation
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- **IDLE**
  - At a rising edge with any `req_valid` set, the winner is the first set bit at or after `rr_ptr`, searching upward with wrap-around.
  - The block latches the winner's data and parity bits into the `tx_*` registers, loads `grant_id`, and moves to LAUNCH.
  - With no `req_valid` set, it stays in IDLE.
- **LAUNCH** (exactly one cycle)
  - `tx_data_valid`=1, `req_ready[grant_id]`=1, `active`=1.
  - The timeout counter is cleared. Next state is WAIT_BUSY.
- **WAIT_BUSY**
  - If `tx_busy`=1, go to WAIT_DONE.
  - Otherwise the counter increments. When the counter reaches `BUSY_TIMEOUT`, pulse `err_timeout` for one cycle, advance `rr_ptr`, and go to IDLE.
- **WAIT_DONE**
  - When `tx_busy`=0, set `rr_ptr` = `grant_id`+1 (mod `NUM_REQ`) and go to IDLE.
- `req_valid` changes outside IDLE are ignored. No re-arbitration happens mid-frame.
- `req_valid` deasserted before the block grants means no grant. No request is queued internally.
- `rr_ptr` wraps from `NUM_REQ`-1 to 0.
- A non-winning requester keeps its valid asserted and is served in a later round.

## Timing
- Reset values (async, immediate): state IDLE, `rr_ptr`=0, `req_ready`=0, `tx_data_valid`=0, `tx_p_data`=0, `tx_par_en`=0, `tx_par_typ`=0, `grant_id`=0, `active`=0, `err_timeout`=0.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Latency: `req_valid` sampled high in IDLE at edge N gives `req_ready` and `tx_data_valid` high during cycle N+1.
- The earliest the next grant can be sampled is the edge after `tx_busy` is observed low in WAIT_DONE.
- Reset asserted mid-frame:
  - All outputs clear immediately. The in-flight requester is not re-acknowledged.
  - After reset, arbitration restarts at requester 0.
- `tx_busy` low in the first WAIT_BUSY cycle is normal; the core's `Busy` is registered and rises one cycle after `Data_valid`.
- Minimum frame turnaround is 4 cycles plus the core's busy time.

## Structure
- Shared header/package `uart_tx_pkg`: state encodings (IDLE=0, LAUNCH=1, WAIT_BUSY=2, WAIT_DONE=3) and default constants for `BUSY_TIMEOUT` and `DATA_WIDTH`.
- Sub-module `rr_priority_picker`: purely combinational. Inputs are `req_valid` and `rr_ptr`; outputs are a one-hot winner and its index. It is instantiated once.
- The top of the block holds the FSM, the timeout counter, `rr_ptr`, and the output/latch registers.

## Test plan
- **Single request:** after reset, requester 2 holds valid with data 0xA5, `par_en`=1, `par_typ`=1.
  - Required: one cycle later `req_ready`=4'b0100 and `tx_data_valid`=1 for exactly one cycle, with `tx_p_data`=0xA5, `tx_par_en`=1, `tx_par_typ`=1 and `grant_id`=2.
  - Core model holds busy for 11 cycles; `active` drops with it and the block returns to IDLE.
- **Fairness:** all 4 requesters valid from reset, each deasserting after its `req_ready`.
  - Required: grants in order 0, 1, 2, 3, each launched only after the previous `tx_busy` falls.
- **Round-robin rotation:** requesters 1 and 3 valid continuously, each frame completing.
  - Required: grant sequence 1, 3, 1, 3, with no back-to-back repeat.
- **Timeout:** the core model never raises busy.
  - Required: `err_timeout` pulses exactly once, 8 cycles after WAIT_BUSY entry; `active`=0; the next grant goes to `grant_id`+1.
- **Reset mid-frame:** `rst` pulled low during WAIT_DONE.
  - Required: all outputs are 0 in the same cycle.
  - After release with requesters 0 and 2 valid, requester 0 is granted first.
- **Idle stability:** `req_valid`=0 for 50 cycles with `tx_busy` toggling randomly.
  - Required: no `req_ready`, no `tx_data_valid`, and state remains IDLE.
